// File: rtl/rv_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_instr_encoder_if
// Description : Bundle interface for the RV32I instruction encoder. It carries
//               the decoded-field stream (valid/ready/last plus fields) and
//               the instruction-memory write port.
//               master : the producer of field bundles and the consumer of
//                        imem writes (boot path or testbench)
//               slave  : the encoder
// Ports       : in_valid, in_ready, in_last, fmt[2:0], alu_ctrl[3:0],
//               funct3_in[2:0], rd/rs1/rs2[4:0], imm[31:0],
//               imem_we, imem_addr[ADDR_W-1:0], imem_wdata[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        fmt;
  logic [3:0]        alu_ctrl;
  logic [2:0]        funct3_in;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_last, fmt, alu_ctrl, funct3_in, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, alu_ctrl, funct3_in, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_instr_encoder
// Description : Sequential RV32I instruction encoder / instruction-memory
//               writer. Accepts decoded field bundles over a valid/ready
//               stream, packs each into a 32-bit machine word and writes the
//               words to consecutive imem addresses starting at 0.
// Ports       : clk           rising-edge clock
//               rst_n         asynchronous active-low reset
//               start         one-cycle pulse: restart the program at addr 0
//               bus (slave)   field stream in, imem write port out
//               count         words written since the last start
//               busy / done   loading / program complete
//               err_illegal   sticky: an illegal bundle was written as NOP
//               err_overflow  sticky: in_valid seen while memory full
// Revision    : 1.0 - initial release
// ============================================================================
module rv_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256   // must not exceed 2**ADDR_W
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  rv_instr_encoder_if.slave       bus,
  output logic [ADDR_W:0]         count,
  output logic                    busy,
  output logic                    done,
  output logic                    err_illegal,
  output logic                    err_overflow
);

  // ALU control codes shared with the control decoder.
  localparam logic [3:0] C_ALU_ADD  = 4'd0;
  localparam logic [3:0] C_ALU_SUB  = 4'd1;
  localparam logic [3:0] C_ALU_SLL  = 4'd2;
  localparam logic [3:0] C_ALU_SLT  = 4'd3;
  localparam logic [3:0] C_ALU_SLTU = 4'd4;
  localparam logic [3:0] C_ALU_XOR  = 4'd5;
  localparam logic [3:0] C_ALU_SRL  = 4'd6;
  localparam logic [3:0] C_ALU_SRA  = 4'd7;
  localparam logic [3:0] C_ALU_OR   = 4'd8;
  localparam logic [3:0] C_ALU_AND  = 4'd9;

  localparam logic [2:0] C_FMT_R    = 3'd0;
  localparam logic [2:0] C_FMT_I    = 3'd1;
  localparam logic [2:0] C_FMT_LD   = 3'd2;
  localparam logic [2:0] C_FMT_S    = 3'd3;
  localparam logic [2:0] C_FMT_B    = 3'd4;
  localparam logic [2:0] C_FMT_U    = 3'd5;
  localparam logic [2:0] C_FMT_J    = 3'd6;

  localparam logic [6:0] C_OP_R     = 7'h33;
  localparam logic [6:0] C_OP_I     = 7'h13;
  localparam logic [6:0] C_OP_LD    = 7'h03;
  localparam logic [6:0] C_OP_S     = 7'h23;
  localparam logic [6:0] C_OP_B     = 7'h63;
  localparam logic [6:0] C_OP_U     = 7'h37;
  localparam logic [6:0] C_OP_J     = 7'h6F;

  localparam logic [31:0]   C_NOP   = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_overflow_q, err_overflow_d;

  logic              in_ready_w;
  logic              accept_w;
  logic [2:0]        alu_f3_w;
  logic [6:0]        alu_f7_w;
  logic              alu_known_w;
  logic              alu_shift_w;
  logic [31:0]       enc_word_w;
  logic              enc_ill_w;

  // --------------------------------------------------------------------------
  // ALU code -> funct3/funct7 lookup (shared by R and I-alu formats)
  // --------------------------------------------------------------------------
  always_comb begin
    alu_f3_w    = 3'b000;
    alu_f7_w    = 7'h00;
    alu_known_w = 1'b1;
    alu_shift_w = 1'b0;
    case (bus.alu_ctrl)
      C_ALU_ADD:  alu_f3_w = 3'b000;
      C_ALU_SUB:  alu_f7_w = 7'h20;
      C_ALU_SLL:  begin alu_f3_w = 3'b001; alu_shift_w = 1'b1; end
      C_ALU_SLT:  alu_f3_w = 3'b010;
      C_ALU_SLTU: alu_f3_w = 3'b011;
      C_ALU_XOR:  alu_f3_w = 3'b100;
      C_ALU_SRL:  begin alu_f3_w = 3'b101; alu_shift_w = 1'b1; end
      C_ALU_SRA:  begin alu_f3_w = 3'b101; alu_f7_w = 7'h20; alu_shift_w = 1'b1; end
      C_ALU_OR:   alu_f3_w = 3'b110;
      C_ALU_AND:  alu_f3_w = 3'b111;
      default:    alu_known_w = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Field packing. Register slots a format does not use stay zero.
  // --------------------------------------------------------------------------
  always_comb begin
    enc_word_w = C_NOP;
    enc_ill_w  = 1'b0;
    case (bus.fmt)
      C_FMT_R: begin
        if (alu_known_w)
          enc_word_w = {alu_f7_w, bus.rs2, bus.rs1, alu_f3_w, bus.rd, C_OP_R};
        else
          enc_ill_w = 1'b1;
      end
      C_FMT_I: begin
        // SUB has no immediate form; shifts carry funct7 in imm[11:5].
        if (!alu_known_w || (bus.alu_ctrl == C_ALU_SUB))
          enc_ill_w = 1'b1;
        else if (alu_shift_w)
          enc_word_w = {alu_f7_w, bus.imm[4:0], bus.rs1, alu_f3_w, bus.rd, C_OP_I};
        else
          enc_word_w = {bus.imm[11:0], bus.rs1, alu_f3_w, bus.rd, C_OP_I};
      end
      C_FMT_LD:
        enc_word_w = {bus.imm[11:0], bus.rs1, bus.funct3_in, bus.rd, C_OP_LD};
      C_FMT_S:
        enc_word_w = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3_in,
                      bus.imm[4:0], C_OP_S};
      C_FMT_B:
        enc_word_w = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3_in,
                      bus.imm[4:1], bus.imm[11], C_OP_B};
      C_FMT_U:
        enc_word_w = {bus.imm[31:12], bus.rd, C_OP_U};
      C_FMT_J:
        enc_word_w = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, C_OP_J};
      default:
        enc_ill_w = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM next-state and write-port logic
  // --------------------------------------------------------------------------
  assign in_ready_w = (state_q == S_LOAD) && (count_q < C_DEPTH) && !start;
  assign accept_w   = bus.in_valid && in_ready_w;

  always_comb begin
    state_d        = state_q;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    imem_we_d      = 1'b0;
    count_d        = count_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;

    if (start) begin
      // Restart from any state; a bundle presented this cycle is dropped.
      state_d        = S_LOAD;
      imem_addr_d    = '0;
      count_d        = '0;
      err_illegal_d  = 1'b0;
      err_overflow_d = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (accept_w) begin
        imem_we_d    = 1'b1;
        // count is below DEPTH on accept, so it fits the address width.
        imem_addr_d  = count_q[ADDR_W-1:0];
        imem_wdata_d = enc_word_w;
        count_d      = count_q + C_ONE;
        if (enc_ill_w)
          err_illegal_d = 1'b1;
        if (bus.in_last)
          state_d = S_DONE;
      end else if (bus.in_valid && (count_q == C_DEPTH)) begin
        err_overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      imem_we_q      <= 1'b0;
      count_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      imem_we_q      <= imem_we_d;
      count_q        <= count_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign count          = count_q;
  assign busy           = (state_q == S_LOAD);
  assign done           = (state_q == S_DONE);
  assign err_illegal    = err_illegal_q;
  assign err_overflow   = err_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_instr_encoder
// Description : Self-checking bench for rv_instr_encoder. A behavioural model
//               tracks the expected outputs every cycle; directed steps cover
//               the reference programs, fill/overflow, illegal bundles and
//               mid-load reset, followed by randomized programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_instr_encoder;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SRL = 6, A_SRA = 7;

  // Instruction-set tables indexed by ALU code: funct3 and funct7.
  int unsigned f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int unsigned f7_tab [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR_W:0] count;
  logic            busy, done, err_illegal, err_overflow;

  rv_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  rv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the expected visible state.
  bit          m_load, m_done, m_we, m_ill, m_ovf, m_acc;
  int          m_cnt, m_addr;
  logic [31:0] m_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input int unsigned fmt, alu, f3, rd, rs1, rs2,
                                          input int unsigned imm, output bit ill);
    int unsigned w;
    ill = 1'b0;
    w   = 0;
    case (fmt)
      0: if (alu > 9) ill = 1'b1;
         else w = (f7_tab[alu] << 25) | (rs2 << 20) | (rs1 << 15) | (f3_tab[alu] << 12) | (rd << 7) | 'h33;
      1: if (alu > 9 || alu == A_SUB) ill = 1'b1;
         else if (alu == A_SLL || alu == A_SRL || alu == A_SRA)
           w = (((f7_tab[alu] << 5) | (imm % 32)) << 20) | (rs1 << 15) | (f3_tab[alu] << 12) | (rd << 7) | 'h13;
         else
           w = ((imm % 4096) << 20) | (rs1 << 15) | (f3_tab[alu] << 12) | (rd << 7) | 'h13;
      2: w = ((imm % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      3: w = (((imm >> 5) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm % 32) << 7) | 'h23;
      4: w = (((imm >> 12) % 2) << 31) | (((imm >> 5) % 64) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((imm >> 1) % 16) << 8) | (((imm >> 11) % 2) << 7) | 'h63;
      5: w = (imm & 32'hFFFF_F000) | (rd << 7) | 'h37;
      6: w = (((imm >> 20) % 2) << 31) | (((imm >> 1) % 1024) << 21) | (((imm >> 11) % 2) << 20)
           | (((imm >> 12) % 256) << 12) | (rd << 7) | 'h6F;
      default: ill = 1'b1;
    endcase
    if (ill) w = 32'h13;
    return w;
  endfunction

  task automatic model_reset();
    m_load = 0; m_done = 0; m_we = 0; m_ill = 0; m_ovf = 0; m_acc = 0;
    m_cnt = 0; m_addr = 0; m_wdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit ill;
    logic [31:0] w;
    m_acc = 0;
    m_we  = 0;
    if (start) begin
      m_load = 1; m_done = 0; m_cnt = 0; m_addr = 0; m_ill = 0; m_ovf = 0;
    end else if (m_load) begin
      if (bus.in_valid && m_cnt < DEPTH) begin
        w = ref_enc(bus.fmt, bus.alu_ctrl, bus.funct3_in, bus.rd, bus.rs1, bus.rs2, bus.imm, ill);
        m_acc = 1; m_we = 1; m_addr = m_cnt; m_wdata = w; m_cnt++;
        if (ill) m_ill = 1;
        if (bus.in_last) begin m_load = 0; m_done = 1; end
      end else if (bus.in_valid) begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", bus.in_ready, (m_load && m_cnt < DEPTH && !start));
    chk("imem_we", bus.imem_we, m_we);
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("imem_wdata", bus.imem_wdata, m_wdata);
    chk("count", count, m_cnt);
    chk("busy", busy, m_load);
    chk("done", done, m_done);
    chk("err_illegal", err_illegal, m_ill);
    chk("err_overflow", err_overflow, m_ovf);
  endtask

  // One clock: check mid-cycle, predict the edge, return 1 time unit after it.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input int fmt, alu, f3, rd, rs1, rs2, input logic [31:0] imm,
                       input bit last, input bit valid);
    bus.fmt = 3'(fmt); bus.alu_ctrl = 4'(alu); bus.funct3_in = 3'(f3);
    bus.rd = 5'(rd); bus.rs1 = 5'(rs1); bus.rs2 = 5'(rs2); bus.imm = imm;
    bus.in_last = last; bus.in_valid = valid;
  endtask

  task automatic set_rand(input bit last, input bit valid);
    set_b($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom, last, valid);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_b(0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    model_reset();

    // Reset values
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // R ADD x1, x2, x3
    pulse_start();
    set_b(0, A_ADD, 0, 1, 2, 3, 32'h0, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    chk("t1_we", bus.imem_we, 1'b1);
    chk("t1_addr", bus.imem_addr, 0);
    chk("t1_wdata", bus.imem_wdata, 32'h003100B3);
    chk("t1_count", count, 1);
    cycle();

    // Back-to-back SUB then ADDI
    pulse_start();
    set_b(0, A_SUB, 0, 5, 6, 7, 32'h0, 1'b0, 1'b1);
    cycle();
    set_b(1, A_ADD, 0, 1, 0, 0, 32'd5, 1'b0, 1'b1);
    chk("t2_wdata0", bus.imem_wdata, 32'h407302B3);
    cycle();
    bus.in_valid = 1'b0;
    chk("t2_we1", bus.imem_we, 1'b1);
    chk("t2_addr1", bus.imem_addr, 1);
    chk("t2_wdata1", bus.imem_wdata, 32'h00500093);
    cycle();

    // Store, then LUI as the last bundle
    pulse_start();
    set_b(3, 0, 2, 0, 1, 2, 32'd8, 1'b0, 1'b1);
    cycle();
    set_b(5, 0, 0, 3, 0, 0, 32'h12345000, 1'b1, 1'b1);
    chk("t3_wdata0", bus.imem_wdata, 32'h0020A423);
    cycle();
    bus.in_valid = 1'b0;
    chk("t3_wdata1", bus.imem_wdata, 32'h123451B7);
    chk("t3_done", done, 1'b1);
    chk("t3_ready", bus.in_ready, 1'b0);
    cycle();

    // Fill to DEPTH and overflow
    pulse_start();
    set_rand(1'b0, 1'b1);
    bus.fmt = 3'd2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (m_acc) begin set_rand(1'b0, 1'b1); bus.fmt = 3'd2; end
    end
    chk("t4_count", count, DEPTH);
    chk("t4_ready", bus.in_ready, 1'b0);
    chk("t4_ovf", err_overflow, 1'b1);
    chk("t4_last_addr", bus.imem_addr, DEPTH - 1);
    bus.in_valid = 1'b0;
    pulse_start();
    chk("t4_clr_count", count, 0);
    chk("t4_clr_ovf", err_overflow, 1'b0);

    // Illegal: SUB in I-alu form
    set_b(1, A_SUB, 0, 4, 4, 0, 32'd3, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    chk("t5_wdata", bus.imem_wdata, 32'h00000013);
    chk("t5_ill", err_illegal, 1'b1);
    chk("t5_count", count, 1);
    cycle();

    // Reset in the cycle after an accept
    pulse_start();
    set_b(6, 0, 0, 9, 0, 0, 32'h000FF7FE, 1'b0, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    chk("t6_we_before", bus.imem_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_we_async", bus.imem_we, 1'b0);
    chk("t6_addr", bus.imem_addr, 0);
    chk("t6_wdata", bus.imem_wdata, 0);
    chk("t6_count", count, 0);
    chk("t6_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Randomized programs, with occasional restarts mid-stream
    for (int p = 0; p < 40; p++) begin
      int len, idx, stall;
      bit pending;
      pulse_start();
      len = $urandom_range(1, 6);
      idx = 0; stall = 0; pending = 0;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 40 && idx < len && stall < 3; c++) begin
        if (!pending) begin
          set_rand(idx == len - 1, ($urandom % 4) != 0);
          pending = bus.in_valid;
        end
        if ($urandom % 32 == 0) start = 1'b1;
        cycle();
        if (start) begin idx = 0; pending = 0; start = 1'b0; end
        else if (m_acc) begin idx++; pending = 0; end
        if (m_cnt == DEPTH && pending) stall++;
      end
      bus.in_valid = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
